seqpu_bus: RTL and testbench

Memory-mapped bus slave directly downstream of the seqpu core. It decodes the core's `address`/`wren_n`/write-data signals into three targets: synchronous word RAM, an 8-bit LED register, and a UART transmitter with a 4-entry byte FIFO. It returns read data with the one-cycle latency that the core's FETCH→EXECUTE and EXECUTE→LOAD sequencing expects.

---
 rtl/seqpu_bus_pkg.sv | 21 ++
 rtl/seqpu_bus_if.sv | 10 +
 rtl/seqpu_bus_uart_tx_fifo.sv | 116 +++++++++++
 rtl/seqpu_bus.sv | 82 ++++++++
 tb/tb_seqpu_bus.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seqpu_bus_pkg.sv
// Shared constants and types for the seqpu bus slave: address map,
// status bit positions and the UART transmitter state encoding.
package seqpu_pkg;

    localparam logic [15:0] UART_DATA = 16'hFF00;
    localparam logic [15:0] UART_STAT = 16'hFF01;
    localparam logic [15:0] LED_REG   = 16'hFF02;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/seqpu_bus_if.sv
// Core-side bus between the seqpu core (master) and the bus slave.
interface seqpu_bus_if;
    logic [15:0] address;
    logic [15:0] wdata;
    logic        wren_n;
    logic [15:0] rdata;

    modport master (output address, output wdata, output wren_n, input rdata);
    modport slave  (input address, input wdata, input wren_n, output rdata);
endinterface

// File: rtl/seqpu_bus_uart_tx_fifo.sv
// 4-entry byte FIFO feeding an 8N1 serializer; frames run back-to-back
// while the FIFO holds data.
module uart_tx_fifo
    import seqpu_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       clr_ovf_i,
    output logic       full_o,
    output logic       empty_o,
    output logic       busy_o,
    output logic       ovf_o,
    output logic       tx_o
);

    logic [7:0]  fifo_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  count_q;
    tx_state_t   state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        ovf_q, ovf_d;
    logic        pop, push_ok, wrap;

    assign full_o  = (count_q == 3'd4);
    assign empty_o = (count_q == 3'd0);
    assign busy_o  = (state_q != TX_IDLE);
    assign ovf_o   = ovf_q;
    assign tx_o    = tx_q;
    assign wrap    = (div_q == 16'(CLK_DIV - 1));
    assign push_ok = push_i && !full_o;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        if (state_q != TX_IDLE) div_d = wrap ? 16'd0 : div_q + 16'd1;
        case (state_q)
            TX_IDLE:  if (!empty_o) pop = 1'b1;
            TX_START: if (wrap) begin
                state_d = TX_DATA;
                bit_d   = 3'd0;
                tx_d    = shift_q[0];
                shift_d = shift_q >> 1;
            end
            TX_DATA:  if (wrap) begin
                if (bit_q == 3'd7) begin
                    state_d = TX_STOP;
                    tx_d    = 1'b1;
                end else begin
                    bit_d   = bit_q + 3'd1;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            // Chaining straight from STOP into START keeps frames gapless.
            TX_STOP:  if (wrap) begin
                if (!empty_o) pop = 1'b1;
                else          state_d = TX_IDLE;
            end
            default:  state_d = TX_IDLE;
        endcase
        if (pop) begin
            state_d = TX_START;
            div_d   = 16'd0;
            bit_d   = 3'd0;
            shift_d = fifo_q[rd_ptr_q];
            tx_d    = 1'b0;
        end
        ovf_d = ovf_q;
        if (push_i && full_o) ovf_d = 1'b1;
        else if (clr_ovf_i)   ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            state_q  <= TX_IDLE;
            div_q    <= 16'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 2'd1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: rtl/seqpu_bus.sv
// Bus slave behind the seqpu core: decodes RAM, LED register and UART,
// returning read data registered one cycle after the address.
module seqpu_bus
    import seqpu_pkg::*;
#(
    parameter int RAM_AW  = 12,
    parameter int CLK_DIV = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    seqpu_bus_if.slave  bus,
    output logic [7:0]  leds_o,
    output logic        uart_tx_o
);

    logic [15:0] ram_q [2**RAM_AW];
    logic [15:0] rdata_q, rdata_d;
    logic [7:0]  leds_q, leds_d;
    logic [15:0] status;
    logic        in_ram, we, push, clr_ovf;
    logic        full, empty, busy, ovf;

    assign in_ram  = ((bus.address >> RAM_AW) == 16'd0);
    assign we      = !bus.wren_n;
    assign push    = we && (bus.address == UART_DATA);
    assign clr_ovf = (bus.address == UART_STAT);

    always_comb begin
        status           = 16'd0;
        status[ST_FULL]  = full;
        status[ST_EMPTY] = empty;
        status[ST_BUSY]  = busy;
        status[ST_OVF]   = ovf;
    end

    // Read mux sees pre-edge state, so read-during-write returns old data.
    always_comb begin
        rdata_d = 16'd0;
        leds_d  = leds_q;
        if (in_ram) begin
            rdata_d = ram_q[bus.address[RAM_AW-1:0]];
        end else begin
            case (bus.address)
                UART_STAT: rdata_d = status;
                LED_REG:   rdata_d = {8'h00, leds_q};
                default:   rdata_d = 16'd0;
            endcase
        end
        if (we && (bus.address == LED_REG)) leds_d = bus.wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (we && in_ram) ram_q[bus.address[RAM_AW-1:0]] <= bus.wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 16'd0;
            leds_q  <= 8'd0;
        end else begin
            rdata_q <= rdata_d;
            leds_q  <= leds_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign leds_o    = leds_q;

    uart_tx_fifo #(.CLK_DIV(CLK_DIV)) u_uart (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .din_i     (bus.wdata[7:0]),
        .clr_ovf_i (clr_ovf),
        .full_o    (full),
        .empty_o   (empty),
        .busy_o    (busy),
        .ovf_o     (ovf),
        .tx_o      (uart_tx_o)
    );

endmodule

// File: tb/tb_seqpu_bus.sv
// Self-checking bench for seqpu_bus: vector table, randomized bus traffic
// against a reference model, and UART frame/overflow/reset sequences.
module tb_seqpu_bus;
    import seqpu_pkg::*;

    localparam int CDIV  = 4;
    localparam int FRAME = 10 * CDIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] leds;
    logic       uart_tx;
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    bit         abort_mon = 1'b0;
    logic [7:0] rx_q [$];
    int         st_q [$];

    seqpu_bus_if bus ();

    seqpu_bus #(.RAM_AW(12), .CLK_DIV(CDIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .leds_o    (leds),
        .uart_tx_o (uart_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [15:0] a, input logic [15:0] wd, input logic wn);
        bus.address = a;
        bus.wdata   = wd;
        bus.wren_n  = wn;
        @(posedge clk);
        #1;
    endtask

    // Line monitor: decodes 8N1 frames by mid-bit sampling, records bytes and start cycles.
    initial begin : monitor
        int         st;
        bit         ok;
        logic [7:0] by;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && !abort_mon && uart_tx == 1'b0) begin
                st = cyc;
                ok = 1'b1;
                by = 8'h00;
                repeat (CDIV / 2) @(posedge clk);
                #1;
                if (abort_mon) ok = 1'b0;
                else chk("mon start bit", {15'd0, uart_tx}, 16'd0);
                for (int b = 0; b < 8; b++) begin
                    repeat (CDIV) @(posedge clk);
                    #1;
                    if (abort_mon) ok = 1'b0;
                    by[b] = uart_tx;
                end
                repeat (CDIV) @(posedge clk);
                #1;
                if (abort_mon) ok = 1'b0;
                if (ok) begin
                    chk("mon stop bit", {15'd0, uart_tx}, 16'd1);
                    rx_q.push_back(by);
                    st_q.push_back(st);
                end
            end
        end
    end

    typedef struct {
        logic [15:0] addr;
        logic [15:0] wd;
        logic        wn;
        bit          chk_rd;
        logic [15:0] exp_rd;
        logic [7:0]  exp_led;
    } vec_t;

    initial begin : main
        vec_t        tbl [$];
        logic [15:0] mref [4096];
        bit          mv [4096];
        logic [7:0]  led_m;
        logic [15:0] a, wd, exp;
        logic        wn;
        bit          do_chk;
        logic [7:0]  bq [6];
        logic [7:0]  fb;
        logic [9:0]  frame;
        bit          all_high;

        bus.address = 16'h3000;
        bus.wdata   = 16'h0000;
        bus.wren_n  = 1'b1;
        #12;
        chk("reset rdata", bus.rdata, 16'h0000);
        chk("reset leds", {8'h00, leds}, 16'h0000);
        chk("reset tx", {15'd0, uart_tx}, 16'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- vector table ----------------
        tbl.push_back('{16'h0005, 16'h1111, 1'b0, 1'b0, 16'h0000, 8'h00});
        tbl.push_back('{16'h0005, 16'h1234, 1'b0, 1'b1, 16'h1111, 8'h00});
        tbl.push_back('{16'h0005, 16'h0000, 1'b1, 1'b1, 16'h1234, 8'h00});
        tbl.push_back('{16'h0000, 16'h0777, 1'b0, 1'b0, 16'h0000, 8'h00});
        tbl.push_back('{16'h2000, 16'hBEEF, 1'b0, 1'b1, 16'h0000, 8'h00});
        tbl.push_back('{16'h2000, 16'h0000, 1'b1, 1'b1, 16'h0000, 8'h00});
        tbl.push_back('{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0777, 8'h00});
        tbl.push_back('{LED_REG,  16'hABCD, 1'b0, 1'b1, 16'h0000, 8'hCD});
        tbl.push_back('{LED_REG,  16'h0000, 1'b1, 1'b1, 16'h00CD, 8'hCD});
        tbl.push_back('{UART_STAT,16'h0000, 1'b1, 1'b1, 16'h0002, 8'hCD});
        tbl.push_back('{UART_DATA,16'h0000, 1'b1, 1'b1, 16'h0000, 8'hCD});
        tbl.push_back('{16'hFFFF, 16'h1234, 1'b0, 1'b1, 16'h0000, 8'hCD});
        tbl.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'h0000, 8'hCD});
        tbl.push_back('{16'h0FFF, 16'hA5A5, 1'b0, 1'b0, 16'h0000, 8'hCD});
        tbl.push_back('{16'h0FFF, 16'h0000, 1'b1, 1'b1, 16'hA5A5, 8'hCD});
        tbl.push_back('{16'h1000, 16'h5A5A, 1'b0, 1'b1, 16'h0000, 8'hCD});
        tbl.push_back('{16'h1000, 16'h0000, 1'b1, 1'b1, 16'h0000, 8'hCD});
        tbl.push_back('{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0777, 8'hCD});
        tbl.push_back('{LED_REG,  16'h0000, 1'b0, 1'b1, 16'h00CD, 8'h00});
        tbl.push_back('{LED_REG,  16'h0000, 1'b1, 1'b1, 16'h0000, 8'h00});
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].addr, tbl[i].wd, tbl[i].wn);
            if (tbl[i].chk_rd) chk($sformatf("vec%0d rdata", i), bus.rdata, tbl[i].exp_rd);
            chk($sformatf("vec%0d leds", i), {8'h00, leds}, {8'h00, tbl[i].exp_led});
        end

        // ---------------- randomized traffic vs model ----------------
        for (int i = 0; i < 4096; i++) mv[i] = 1'b0;
        led_m = 8'h00;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0:       a = 16'($urandom_range(0, 15));
                1:       a = 16'($urandom_range(16'h0FF0, 16'h0FFF));
                2:       a = 16'h1000 + 16'($urandom_range(0, 16'hEEFF));
                3:       a = LED_REG;
                4:       a = UART_STAT;
                default: a = 16'hFF03 + 16'($urandom_range(0, 252));
            endcase
            wd = 16'($urandom);
            wn = 1'($urandom_range(0, 1));
            do_chk = 1'b1;
            exp = 16'h0000;
            if (a < 16'd4096) begin
                do_chk = mv[a[11:0]];
                exp    = mref[a[11:0]];
            end else if (a == LED_REG) begin
                exp = {8'h00, led_m};
            end else if (a == UART_STAT) begin
                exp = 16'h0002;
            end
            step(a, wd, wn);
            if (do_chk) chk("rand rdata", bus.rdata, exp);
            if (!wn && a < 16'd4096) begin
                mref[a[11:0]] = wd;
                mv[a[11:0]]   = 1'b1;
            end
            if (!wn && a == LED_REG) led_m = wd[7:0];
            chk("rand leds", {8'h00, leds}, {8'h00, led_m});
        end

        // ---------------- single frame, exact bit timing ----------------
        rx_q.delete();
        st_q.delete();
        fb    = 8'h41;
        frame = {1'b1, fb, 1'b0};
        step(UART_DATA, 16'h0041, 1'b0);
        for (int k = 0; k < FRAME; k++) begin
            if (k == 20) begin
                step(UART_STAT, 16'h0000, 1'b1);
                chk("status mid-frame", bus.rdata, 16'h0006);
            end else begin
                step(16'h3000, 16'h0000, 1'b1);
            end
            chk($sformatf("frame bit k=%0d", k), {15'd0, uart_tx}, {15'd0, frame[k / CDIV]});
        end
        step(16'h3000, 16'h0000, 1'b1);
        step(UART_STAT, 16'h0000, 1'b1);
        chk("status after frame", bus.rdata, 16'h0002);
        chk("tx idle after frame", {15'd0, uart_tx}, 16'd1);
        repeat (4) step(16'h3000, 16'h0000, 1'b1);
        chk("mon frame count", 16'(rx_q.size()), 16'd1);
        if (rx_q.size() == 1) chk("mon frame byte", {8'h00, rx_q[0]}, 16'h0041);

        // ---------------- overflow and back-to-back frames ----------------
        rx_q.delete();
        st_q.delete();
        for (int i = 0; i < 6; i++) begin
            bq[i] = 8'($urandom);
            step(UART_DATA, {8'($urandom), bq[i]}, 1'b0);
        end
        step(UART_STAT, 16'h0000, 1'b1);
        chk("status overflow", bus.rdata, 16'h000D);
        step(UART_STAT, 16'h0000, 1'b1);
        chk("status ovf cleared", bus.rdata, 16'h0005);
        repeat (5 * FRAME + 10) step(16'h3000, 16'h0000, 1'b1);
        chk("ovf frame count", 16'(rx_q.size()), 16'd5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++)
            chk($sformatf("ovf byte %0d", i), {8'h00, rx_q[i]}, {8'h00, bq[i]});
        for (int i = 1; i < st_q.size(); i++)
            chk($sformatf("b2b spacing %0d", i), 16'(st_q[i] - st_q[i-1]), 16'(FRAME));
        step(UART_STAT, 16'h0000, 1'b1);
        chk("status drained", bus.rdata, 16'h0002);

        // ---------------- reset during DATA ----------------
        step(LED_REG, 16'h005A, 1'b0);
        chk("leds before reset", {8'h00, leds}, 16'h005A);
        step(UART_DATA, 16'h0000, 1'b0);
        repeat (20) step(16'h3000, 16'h0000, 1'b1);
        #3;
        chk("tx low in data", {15'd0, uart_tx}, 16'd0);
        abort_mon = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("tx async reset", {15'd0, uart_tx}, 16'd1);
        chk("leds async reset", {8'h00, leds}, 16'h0000);
        chk("rdata async reset", bus.rdata, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        step(UART_STAT, 16'h0000, 1'b1);
        chk("status after reset", bus.rdata, 16'h0002);
        chk("leds after reset", {8'h00, leds}, 16'h0000);
        all_high = 1'b1;
        for (int k = 0; k < 2 * FRAME; k++) begin
            step(16'h3000, 16'h0000, 1'b1);
            if (uart_tx !== 1'b1) all_high = 1'b0;
        end
        chk("tx stays idle after reset", {15'd0, all_high}, 16'd1);
        abort_mon = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
